mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- Column-serial MixColumns stage of the AES encryption round datapath.
- Sits directly downstream of the combinational row-shift stage and consumes its 128-bit state.
- Registers the state and transforms COLS_PER_CYCLE columns per clock using GF(2^8) xtime arithmetic.
- Emits the result over a valid/ready handshake; last_round bypasses the transform for the AES final round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NRUN (localparam), 4/COLS_PER_CYCLE, number of RUN cycles per block.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  upstream has a state on state_in.
- in_ready  output  1  block can accept; high only in IDLE.
- state_in  input  [0:127]  input state, column-major. Column c = bits 32c..32c+31; row r of column c = bits 32c+8r..32c+8r+7; bit 32c+8r is the byte MSB.
- last_round  input  1  sampled with state_in; 1 = pass the state through unchanged.
- out_valid  output  1  state_out holds a finished block.
- out_ready  input  1  downstream accepts.
- state_out  output  [0:127]  result, same byte layout as state_in.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: at a rising edge with rst_n=0 the FSM goes to IDLE, col_idx=0, working register=0. This applies from any state and aborts an in-flight block; the block is discarded and not emitted.
- Outputs after reset: out_valid=0, busy=0, state_out=0, in_ready=1.
- FSM states are IDLE, RUN and DONE. Moore outputs: in_ready=(IDLE), out_valid=(DONE), busy=(RUN|DONE).
- IDLE: accept on in_valid&in_ready. On acceptance, capture state_in into the working register and last_round into byp. Next state is DONE if last_round=1, otherwise RUN with col_idx=0.
- RUN: at each edge, replace columns col_idx..col_idx+COLS_PER_CYCLE-1 of the working register in place; col_idx += COLS_PER_CYCLE. After the column-3 group, go to DONE.
- DONE: state_out = working register, held stable while out_valid&~out_ready. On out_valid&out_ready go to IDLE. in_ready is still 0 in that cycle, so there is no same-cycle re-accept.
- Latency: with acceptance at edge T, out_valid is first high in cycle T+NRUN+1; with bypass, in cycle T+1.
- Throughput: one block per NRUN+2 cycles when out_ready is held at 1.
- state_out may show partial columns during RUN; it is valid only while out_valid=1.
- in_valid and state_in are ignored whenever in_ready=0. last_round is ignored except at acceptance.
- Column math for input bytes a0..a3 (rows 0..3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0); 3x = xtime(x)^x. All arithmetic is 8-bit, with no carries between bytes.
- Simultaneous events: rst_n=0 dominates any handshake in the same cycle. A stall (out_ready=0) in DONE holds indefinitely.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, then release -> out_valid=0, busy=0, state_out=0, in_ready=1.
- FIPS-197 column vectors, last_round=0, out_ready=1. Input db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid first high exactly NRUN+1 cycles after acceptance (5 cycles for COLS_PER_CYCLE=1). Second vector: d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Bypass: last_round=1, input 00112233_44556677_8899aabb_ccddeeff -> identical output, out_valid high 1 cycle after acceptance.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> state_out and out_valid stable and in_ready=0 throughout; release -> one transfer, then in_ready=1 on the next cycle.
- Busy-time input: toggle in_valid with a different state_in during RUN -> ignored; the output equals the first block's result.
- Mid-operation reset: assert rst_n=0 for one edge during the 2nd RUN cycle -> IDLE and no out_valid pulse. The next block runs correctly. Repeat for COLS_PER_CYCLE=1, 2 and 4.

Source files
------------

// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
//
// Column-serial AES MixColumns stage. Accepts the 128-bit state from the
// row-shift stage, registers it, and transforms COLS_PER_CYCLE columns per
// clock in place. The finished block is offered on a valid/ready handshake.
// last_round=1 skips the transform so the state passes through unchanged
// (the AES final round has no MixColumns).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous, active-low reset (aborts any block in flight)
//   in_valid   upstream offers state_in / last_round
//   in_ready   block can accept (IDLE only)
//   state_in   input state, column-major, byte MSB at the lowest index
//   last_round sampled at acceptance; 1 = bypass the transform
//   out_valid  state_out holds a finished block (DONE)
//   out_ready  downstream accepts
//   state_out  result, same byte layout as state_in
//   busy       high while RUN or DONE
// ---------------------------------------------------------------------------
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] state_in,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] state_out,
   output logic         busy
);

   localparam int NRUN = 4 / COLS_PER_CYCLE;
   // col_idx value of the final column group of a block
   localparam logic [1:0] LAST_IDX = 2'((NRUN - 1) * COLS_PER_CYCLE);
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state_reg, state_next;
   logic [1:0]   col_idx_reg, col_idx_next;
   logic [0:127] work_reg, work_next;

   // GF(2^8) multiply by 2, reducing by the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column: rows 0..3 sit at byte offsets 0, 8, 16, 24
   function automatic logic [0:31] mix_col(input logic [0:31] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = c[0:7];
      a1 = c[8:15];
      a2 = c[16:23];
      a3 = c[24:31];
      b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

   // Per-lane column position and transformed column for the current group
   logic [1:0]  col_pos [COLS_PER_CYCLE];
   logic [0:31] col_new [COLS_PER_CYCLE];

   for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      assign col_pos[gi] = col_idx_reg + 2'(gi);
      assign col_new[gi] = mix_col(work_reg[{col_pos[gi], 5'b0} +: 32]);
   end

   // State register (plus datapath registers)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         col_idx_reg <= 2'd0;
         work_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         col_idx_reg <= col_idx_next;
         work_reg    <= work_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next   = state_reg;
      col_idx_next = col_idx_reg;
      work_next    = work_reg;
      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               work_next    = state_in;
               col_idx_next = 2'd0;
               // Final round has no MixColumns: go straight to the output
               state_next   = last_round ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               work_next[{col_pos[i], 5'b0} +: 32] = col_new[i];
            end
            col_idx_next = col_idx_reg + COL_STEP;
            if (col_idx_reg == LAST_IDX) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Moore outputs
   always_comb begin
      in_ready  = (state_reg == S_IDLE);
      out_valid = (state_reg == S_DONE);
      busy      = (state_reg == S_RUN) || (state_reg == S_DONE);
   end

   assign state_out = work_reg;

endmodule

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter
//
// Drives three instances (COLS_PER_CYCLE = 1, 2, 4) from shared stimulus,
// with a separate reset per instance so a reset can be placed in each one's
// RUN phase. Expected values are FIPS-197 MixColumns vectors.
// ---------------------------------------------------------------------------
module tb_mix_columns_iter;

   logic         clk;
   logic         in_valid;
   logic [0:127] state_in;
   logic         last_round;
   logic         out_ready;

   logic         rst_n_w     [3];
   logic         in_ready_w  [3];
   logic         out_valid_w [3];
   logic         busy_w      [3];
   logic [0:127] state_out_w [3];

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mix_columns_iter #(
         .COLS_PER_CYCLE(1 << gi)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n_w[gi]),
         .in_valid   (in_valid),
         .in_ready   (in_ready_w[gi]),
         .state_in   (state_in),
         .last_round (last_round),
         .out_valid  (out_valid_w[gi]),
         .out_ready  (out_ready),
         .state_out  (state_out_w[gi]),
         .busy       (busy_w[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offer one block; optionally stall the output and toggle in_valid with
   // junk while the instances are busy. Checks latency and result per DUT.
   task automatic run_block(input logic [0:127] din, input logic lr,
                            input logic [0:127] exp, input bit noise);
      bit           seen [3];
      int           lat  [3];
      logic [0:127] got  [3];
      for (int d = 0; d < 3; d++) begin
         seen[d] = 1'b0;
         lat[d]  = 0;
         got[d]  = '0;
      end
      $display("[TB] block in=%h last_round=%0d stall=%0d", din, lr, noise);
      state_in   = din;
      last_round = lr;
      in_valid   = 1'b1;
      out_ready  = !noise;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         for (int d = 0; d < 3; d++) begin
            if (!seen[d] && out_valid_w[d]) begin
               seen[d] = 1'b1;
               lat[d]  = k;
               got[d]  = state_out_w[d];
            end
            if (k == 1)
               check($sformatf("busy_after_accept d%0d", d), 128'(busy_w[d]), 128'(1));
            if (noise && k >= 5 && k < 15) begin
               check($sformatf("stall_data d%0d k%0d", d, k), state_out_w[d], exp);
               check($sformatf("stall_valid d%0d k%0d", d, k), 128'(out_valid_w[d]), 128'(1));
               check($sformatf("stall_in_ready d%0d k%0d", d, k), 128'(in_ready_w[d]), 128'(0));
            end
            if (noise && k == 16) begin
               check($sformatf("post_xfer_in_ready d%0d", d), 128'(in_ready_w[d]), 128'(1));
               check($sformatf("post_xfer_valid d%0d", d), 128'(out_valid_w[d]), 128'(0));
            end
         end
         if (noise && k < 15) begin
            in_valid   = k[0];
            state_in   = {4{32'hdeadbeef}} ^ 128'(k);
            last_round = k[1];
            out_ready  = 1'b0;
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
         check($sformatf("latency d%0d", d), 128'(lat[d]), lr ? 128'(1) : 128'((4 >> d) + 1));
         check($sformatf("result d%0d", d), got[d], exp);
         check($sformatf("idle_after d%0d", d), 128'(in_ready_w[d]), 128'(1));
      end
   endtask

   // Accept a block, then reset each instance during its RUN phase.
   task automatic abort_block(input logic [0:127] din);
      bit saw [3];
      for (int d = 0; d < 3; d++) saw[d] = 1'b0;
      $display("[TB] block in=%h aborted by reset", din);
      state_in   = din;
      last_round = 1'b0;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         for (int d = 0; d < 3; d++) begin
            if (out_valid_w[d]) saw[d] = 1'b1;
            if (k == 3) begin
               check($sformatf("abort_in_ready d%0d", d), 128'(in_ready_w[d]), 128'(1));
               check($sformatf("abort_busy d%0d", d), 128'(busy_w[d]), 128'(0));
               check($sformatf("abort_state_out d%0d", d), state_out_w[d], 128'(0));
            end
         end
         // Edge 2 is the only RUN edge for 4 columns/cycle; edge 3 ends the
         // second RUN cycle for 1 and 2 columns/cycle.
         rst_n_w[2] = !(k == 1);
         rst_n_w[0] = !(k == 2);
         rst_n_w[1] = !(k == 2);
         @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++)
         check($sformatf("abort_no_valid d%0d", d), 128'(saw[d]), 128'(0));
   endtask

   initial begin
      in_valid   = 1'b0;
      state_in   = '0;
      last_round = 1'b0;
      out_ready  = 1'b1;
      for (int d = 0; d < 3; d++) rst_n_w[d] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst_n_w[d] = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_out_valid d%0d", d), 128'(out_valid_w[d]), 128'(0));
         check($sformatf("reset_busy d%0d", d), 128'(busy_w[d]), 128'(0));
         check($sformatf("reset_state_out d%0d", d), state_out_w[d], 128'(0));
         check($sformatf("reset_in_ready d%0d", d), 128'(in_ready_w[d]), 128'(1));
      end

      run_block(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
      run_block(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
                128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b0);
      run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
      run_block(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1);
      abort_block(128'hdb135345_f20a225c_01010101_c6c6c6c6);
      run_block(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
                128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
